// File: rtl/timer_share_if.sv
// Requester-side bundle of the shared timer: per-requester req/delay/ack in,
// grant/done plus shared busy/count status out.
interface timer_share_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] delay;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic [3:0]         count;
  logic [N_REQ-1:0]   done;

  modport master (
    output req, delay, ack,
    input  grant, busy, count, done
  );

  modport slave (
    input  req, delay, ack,
    output grant, busy, count, done
  );
endinterface

// File: rtl/timer_share_ctrl.sv
// Round-robin owner of one shared slow/fast countdown timer among N_REQ requesters.
//   state    | meaning
//   ST_IDLE  | no owner; arbitrate over req starting after last
//   ST_COUNT | owner's countdown running, (delay+1)*TICK cycles
//   ST_WAIT  | countdown expired; done held until ack[owner]
module timer_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int TICK  = 1000
) (
  input  logic         clk,
  input  logic         reset,
  timer_share_if.slave bus
);

  localparam int FW = $clog2(TICK);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]         state;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      last;
  logic [3:0]         scount;
  logic [FW-1:0]      fcount;

  logic [N_REQ-1:0]   owner_oh;
  logic               owner_req;
  logic               owner_ack;
  logic [PW:0]        rr_base;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [PW:0]        pick_off;
  logic [PW:0]        pick_sum;
  logic [PW-1:0]      winner;
  logic [3:0]         sel_delay;

  assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
  assign owner_req = |(owner_oh & bus.req);
  assign owner_ack = |(owner_oh & bus.ack);

  // Rotate req so bit 0 is the requester just after last; lowest set bit wins.
  assign rr_base = {1'b0, last} + (PW+1)'(1);
  assign req_dbl = {bus.req, bus.req} >> rr_base;
  assign req_rot = req_dbl[N_REQ-1:0];

  always_comb begin
    pick_off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) pick_off = (PW+1)'(j);
    end
    pick_sum = rr_base + pick_off;
    if (pick_sum >= (PW+1)'(N_REQ)) pick_sum = pick_sum - (PW+1)'(N_REQ);
    winner = pick_sum[PW-1:0];
  end

  always_comb begin
    sel_delay = 4'd0;
    for (int j = 0; j < N_REQ; j++) begin
      if (winner == PW'(j)) sel_delay = bus.delay[4*j +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      owner  <= '0;
      last   <= PW'(N_REQ - 1);
      scount <= 4'd0;
      fcount <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            owner  <= winner;
            scount <= sel_delay;
            fcount <= '0;
            state  <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!owner_req) begin
            state  <= ST_IDLE;
            last   <= owner;
            fcount <= '0;
          end else if (fcount == FW'(TICK - 1)) begin
            fcount <= '0;
            if (scount == 4'd0) state <= ST_WAIT;
            else scount <= scount - 4'd1;
          end else begin
            fcount <= fcount + FW'(1);
          end
        end
        ST_WAIT: begin
          if (owner_ack) begin
            state <= ST_IDLE;
            last  <= owner;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant = (state != ST_IDLE) ? owner_oh : '0;
  assign bus.busy  = (state != ST_IDLE);
  assign bus.count = (state == ST_COUNT) ? scount : 4'd0;
  assign bus.done  = (state == ST_WAIT) ? owner_oh : '0;

endmodule
